// File: rtl/keypad_pkg.sv
// Shared constants, state encoding and helpers for the 4x4 keypad scanner.
// Key index layout: 4*row + col; 0..9 are digits, 10..15 function keys.
package keypad_pkg;

    localparam logic [4:0] KEY_NONE      = 5'h10;
    localparam int unsigned KEY_FUNC_BASE = 10;
    localparam logic [3:0] COL_IDLE      = 4'b1110;

    typedef enum logic [1:0] {
        SCAN,
        PRESS_DEB,
        HELD,
        REL_DEB
    } kp_state_e;

    // Key index from row/column bit positions.
    function automatic logic [4:0] key_index(
        input logic [1:0] row,
        input logic [1:0] col
    );
        return {1'b0, row, col};
    endfunction

    // Next column in scan order: 1110->1101->1011->0111->1110.
    function automatic logic [3:0] col_rotl(input logic [3:0] col);
        return {col[2:0], col[3]};
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider: one-clock tick strobe every DIV clocks.
// The strobe is high while the counter sits at its last value.
module scan_tick_gen #(
    parameter int unsigned DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_tick
);

    localparam int unsigned W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] r_cnt;
    logic         w_wrap;

    assign w_wrap = (r_cnt == LAST);
    assign o_tick = w_wrap;

    // Count 0..DIV-1 and wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner with press/release debounce.
// Emits keycode plus a fixed-width key_ready pulse per accepted press.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_TICKS = 20,
    parameter int unsigned READY_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [4:0] keycode,
    output logic       key_ready,
    output logic       key_down
);

    localparam int unsigned DW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS + 1) : 1;
    localparam int unsigned RW = (READY_CYCLES > 1) ? $clog2(READY_CYCLES + 1) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_TICKS - 1);
    localparam logic [RW-1:0] RDY_LOAD = RW'(READY_CYCLES);

    logic [3:0]    r_row_s1;
    logic [3:0]    r_row_s2;
    kp_state_e     r_state;
    logic [3:0]    r_col;
    logic [4:0]    r_cand;
    logic [DW-1:0] r_deb_cnt;
    logic [RW-1:0] r_rdy_cnt;
    logic          r_ready;
    logic [4:0]    r_code;
    logic          r_down;

    kp_state_e     w_state_nxt;
    logic [3:0]    w_col_nxt;
    logic [4:0]    w_cand_nxt;
    logic [DW-1:0] w_deb_nxt;
    logic [RW-1:0] w_rdy_nxt;
    logic          w_ready_nxt;
    logic [4:0]    w_code_nxt;
    logic          w_down_nxt;

    logic          w_tick;
    logic          w_rows_idle;
    logic [1:0]    w_row_idx;
    logic [1:0]    w_col_idx;
    logic [4:0]    w_key;
    logic          w_same_key;

    scan_tick_gen #(
        .DIV (SCAN_DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_tick (w_tick)
    );

    // Two-flop synchronizer for the asynchronous row inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_s1 <= 4'hF;
            r_row_s2 <= 4'hF;
        end else begin
            r_row_s1 <= row_in;
            r_row_s2 <= r_row_s1;
        end
    end

    assign w_rows_idle = &r_row_s2;

    // Lowest active-low row wins when several rows are pulled down.
    always_comb begin
        w_row_idx = 2'd3;
        if (!r_row_s2[0]) begin
            w_row_idx = 2'd0;
        end else if (!r_row_s2[1]) begin
            w_row_idx = 2'd1;
        end else if (!r_row_s2[2]) begin
            w_row_idx = 2'd2;
        end
    end

    // Position of the single driven (low) column.
    always_comb begin
        w_col_idx = 2'd0;
        unique case (r_col)
            4'b1110: w_col_idx = 2'd0;
            4'b1101: w_col_idx = 2'd1;
            4'b1011: w_col_idx = 2'd2;
            4'b0111: w_col_idx = 2'd3;
            default: w_col_idx = 2'd0;
        endcase
    end

    assign w_key      = key_index(w_row_idx, w_col_idx);
    assign w_same_key = !w_rows_idle && (w_key == r_cand);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= SCAN;
            r_col     <= COL_IDLE;
            r_cand    <= KEY_NONE;
            r_deb_cnt <= '0;
            r_rdy_cnt <= '0;
            r_ready   <= 1'b0;
            r_code    <= KEY_NONE;
            r_down    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_col     <= w_col_nxt;
            r_cand    <= w_cand_nxt;
            r_deb_cnt <= w_deb_nxt;
            r_rdy_cnt <= w_rdy_nxt;
            r_ready   <= w_ready_nxt;
            r_code    <= w_code_nxt;
            r_down    <= w_down_nxt;
        end
    end

    // Next-state logic: ready pulse timer every clk, FSM on ticks only.
    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_cand_nxt  = r_cand;
        w_deb_nxt   = r_deb_cnt;
        w_rdy_nxt   = r_rdy_cnt;
        w_ready_nxt = r_ready;
        w_code_nxt  = r_code;
        w_down_nxt  = r_down;

        if (r_rdy_cnt != '0) begin
            w_rdy_nxt   = r_rdy_cnt - RW'(1);
            w_ready_nxt = (r_rdy_cnt != RW'(1));
        end

        if (w_tick) begin
            unique case (r_state)
                SCAN: begin
                    if (w_rows_idle) begin
                        w_col_nxt = col_rotl(r_col);
                    end else begin
                        w_cand_nxt  = w_key;
                        w_deb_nxt   = DW'(1);
                        w_state_nxt = PRESS_DEB;
                    end
                end
                PRESS_DEB: begin
                    if (!w_same_key) begin
                        w_state_nxt = SCAN;
                    end else if (r_deb_cnt >= DEB_LAST) begin
                        w_deb_nxt   = '0;
                        w_code_nxt  = r_cand;
                        w_ready_nxt = 1'b1;
                        w_rdy_nxt   = RDY_LOAD;
                        w_down_nxt  = 1'b1;
                        w_state_nxt = HELD;
                    end else begin
                        w_deb_nxt = r_deb_cnt + DW'(1);
                    end
                end
                HELD: begin
                    if (w_rows_idle) begin
                        w_deb_nxt   = DW'(1);
                        w_state_nxt = REL_DEB;
                    end
                end
                REL_DEB: begin
                    if (!w_rows_idle) begin
                        w_state_nxt = HELD;
                    end else if (r_deb_cnt >= DEB_LAST) begin
                        w_deb_nxt   = '0;
                        w_down_nxt  = 1'b0;
                        w_col_nxt   = col_rotl(r_col);
                        w_state_nxt = SCAN;
                    end else begin
                        w_deb_nxt = r_deb_cnt + DW'(1);
                    end
                end
                default: begin
                    w_state_nxt = SCAN;
                end
            endcase
        end
    end

    assign col_out   = r_col;
    assign keycode   = r_code;
    assign key_ready = r_ready;
    assign key_down  = r_down;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a behavioural keypad matrix.
// Pulses are measured at negedge: count, width and keycode at fall.
module tb_keypad_scan;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [4:0]  keycode;
    logic        key_ready;
    logic        key_down;
    logic [15:0] keys = '0;

    int          errs = 0;
    int          checks = 0;
    int          pulses = 0;
    int          run_len = 0;
    int          last_w = 0;
    logic [4:0]  last_code = '0;
    logic        prev_rdy = 1'b0;

    always #5 clk = ~clk;

    keypad_scan #(
        .SCAN_DIV       (4),
        .DEBOUNCE_TICKS (3),
        .READY_CYCLES   (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_in    (row_in),
        .col_out   (col_out),
        .keycode   (keycode),
        .key_ready (key_ready),
        .key_down  (key_down)
    );

    // Switch matrix: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
    end

    // Pulse monitor.
    always @(negedge clk) begin
        if (key_ready) begin
            run_len++;
        end else if (prev_rdy) begin
            pulses++;
            last_w = run_len;
            last_code = keycode;
            run_len = 0;
        end
        prev_rdy = key_ready;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pulse(input int base, input int lim);
        int n = 0;
        while (pulses == base && n < lim) begin
            @(negedge clk);
            n++;
        end
        clks(1);
    endtask

    task automatic wait_up(input int lim, output int n);
        n = 0;
        while (key_down && n < lim) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int p0;
        int n;

        // Reset and asynchronous re-reset mid-scan.
        clks(3);
        rst_n = 1'b1;
        clks(6);
        check("t1_scan_col", col_out, 4'b1101);
        rst_n = 1'b0;
        #1;
        check("t1_col", col_out, 4'b1110);
        check("t1_code", keycode, 5'h10);
        check("t1_ready", key_ready, 0);
        check("t1_down", key_down, 0);
        clks(2);
        rst_n = 1'b1;

        // Clean press of index 6 held 40 clks.
        p0 = pulses;
        keys[6] = 1'b1;
        clks(40);
        check("t2_cnt", pulses - p0, 1);
        check("t2_width", last_w, 4);
        check("t2_code", last_code, 6);
        check("t2_down", key_down, 1);
        keys = '0;
        clks(4);
        check("t2_down_hold", key_down, 1);
        wait_up(40, n);
        check("t2_up", key_down, 0);
        check("t2_up_lat", (n + 4 >= 9) && (n + 4 <= 16), 1);

        // Bouncing key 0, then a steady press.
        p0 = pulses;
        for (int i = 0; i < 3; i++) begin
            keys[0] = 1'b1;
            clks(5);
            keys[0] = 1'b0;
            clks(5);
        end
        check("t3_bounce", pulses - p0, 0);
        keys[0] = 1'b1;
        wait_pulse(p0, 60);
        check("t3_cnt", pulses - p0, 1);
        check("t3_code", last_code, 0);
        keys = '0;
        wait_up(40, n);
        check("t3_up", key_down, 0);

        // Two rows low in column 3.
        p0 = pulses;
        keys[3] = 1'b1;
        keys[15] = 1'b1;
        wait_pulse(p0, 60);
        check("t4_code", last_code, 3);
        clks(20);
        check("t4_cnt", pulses - p0, 1);
        keys = '0;
        wait_up(40, n);
        check("t4_up", key_down, 0);

        // Long hold of index 9 with a one-tick release glitch.
        p0 = pulses;
        keys[9] = 1'b1;
        clks(60);
        check("t5_code", last_code, 9);
        keys[9] = 1'b0;
        clks(4);
        keys[9] = 1'b1;
        clks(136);
        check("t5_cnt", pulses - p0, 1);
        check("t5_down", key_down, 1);
        keys = '0;
        wait_up(40, n);
        check("t5_up", key_down, 0);
        p0 = pulses;
        keys[15] = 1'b1;
        wait_pulse(p0, 60);
        check("t5_cnt15", pulses - p0, 1);
        check("t5_code15", last_code, 15);
        keys = '0;
        wait_up(40, n);

        // Reset while a press is being debounced.
        rst_n = 1'b0;
        clks(2);
        p0 = pulses;
        rst_n = 1'b1;
        keys[0] = 1'b1;
        clks(6);
        check("t6_no_acc", key_down, 0);
        rst_n = 1'b0;
        #1;
        check("t6_ready", key_ready, 0);
        check("t6_code", keycode, 5'h10);
        check("t6_col", col_out, 4'b1110);
        keys = '0;
        clks(3);
        rst_n = 1'b1;
        check("t6_col_rel", col_out, 4'b1110);
        clks(5);
        check("t6_rot", col_out, 4'b1101);
        clks(20);
        check("t6_cnt", pulses - p0, 0);
        check("t6_code_end", keycode, 5'h10);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
